// File: rtl/li_relay_station_pkg.sv
// Shared latency-insensitive link helpers.
//   li_xfer  : a token moves across an li_link when valid is high and stop is low
//   li_cnt_w : bit width needed to hold an occupancy of 0..depth
//   li_ptr_w : bit width needed to address depth storage entries
package li_pkg;

  function automatic logic li_xfer(input logic valid, input logic stop);
    return valid & ~stop;
  endfunction

  function automatic int unsigned li_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned li_ptr_w(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/li_relay_station_mem.sv
// Relay station storage: DEPTH x DWIDTH register array, no reset.
//   clk     : write clock
//   wr_en   : write enable
//   wr_addr : write entry index
//   wr_data : write payload
//   rd_addr : asynchronous read entry index
//   rd_data : asynchronous read payload
module li_rs_mem #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PW     = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PW-1:0]     wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [PW-1:0]     rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/li_relay_station.sv
// Latency-insensitive relay station on one li_link channel (data/valid/stop).
// Every output is registered so no combinational path crosses the stage.
// Also latches a sticky flag when upstream violates the hold-while-stopped rule.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   i_data       : upstream payload
//   i_data_valid : upstream token present
//   i_data_stop  : registered backpressure to upstream
//   o_data       : registered FIFO head payload
//   o_data_valid : registered downstream token present
//   o_data_stop  : backpressure from downstream
//   o_count      : current occupancy
//   o_proto_err  : sticky upstream protocol violation
module li_relay_station
  import li_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DWIDTH-1:0]          i_data,
  input  logic                       i_data_valid,
  output logic                       i_data_stop,
  output logic [DWIDTH-1:0]          o_data,
  output logic                       o_data_valid,
  input  logic                       o_data_stop,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_proto_err
);

  localparam int unsigned CW = li_cnt_w(DEPTH);
  localparam int unsigned PW = li_ptr_w(DEPTH);

  logic [CW-1:0]     count, count_nxt;
  logic [PW-1:0]     wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic              push, pop;
  logic [DWIDTH-1:0] mem_rd, head_nxt;
  logic              prev_stopped;
  logic [DWIDTH-1:0] prev_data;
  logic              proto_viol;

  // Explicit compare-and-clear so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  li_rs_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .PW     (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .rd_addr (rd_ptr_nxt),
    .rd_data (mem_rd)
  );

  always_comb begin
    push       = li_xfer(i_data_valid, i_data_stop);
    pop        = li_xfer(o_data_valid, o_data_stop);
    count_nxt  = count + CW'(push) - CW'(pop);
    wr_ptr_nxt = push ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    // o_data is a register copy of the head. When nothing stays stored past
    // this edge, the next head is the token arriving now (bypassing the
    // array, which is written on the same edge); otherwise it is already
    // stored at rd_ptr_nxt.
    head_nxt   = (count == CW'(pop)) ? i_data : mem_rd;
    proto_viol = prev_stopped && (!i_data_valid || (i_data != prev_data));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      i_data_stop  <= 1'b0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_proto_err  <= 1'b0;
      prev_stopped <= 1'b0;
      prev_data    <= '0;
    end else begin
      count        <= count_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      i_data_stop  <= (count_nxt == CW'(DEPTH));
      o_data_valid <= (count_nxt != '0);
      if (count_nxt != '0) o_data <= head_nxt;
      prev_stopped <= i_data_valid && i_data_stop;
      prev_data    <= i_data;
      if (proto_viol) o_proto_err <= 1'b1;
    end
  end

  assign o_count = count;

endmodule

// File: tb/tb_li_relay_station.sv
module tb_li_relay_station;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  // DEPTH=4 instance
  logic [15:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        i_data_stop;
  logic [15:0] o_data;
  logic        o_data_valid;
  logic        o_data_stop = 1'b0;
  logic [2:0]  o_count;
  logic        o_proto_err;

  // DEPTH=2 instance
  logic [15:0] e2_i_data = '0;
  logic        e2_i_data_valid = 1'b0;
  logic        e2_i_data_stop;
  logic [15:0] e2_o_data;
  logic        e2_o_data_valid;
  logic        e2_o_data_stop = 1'b0;
  logic [1:0]  e2_o_count;
  logic        e2_o_proto_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  li_relay_station #(.DWIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .i_data(i_data), .i_data_valid(i_data_valid), .i_data_stop(i_data_stop),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_data_stop(o_data_stop),
    .o_count(o_count), .o_proto_err(o_proto_err)
  );

  li_relay_station #(.DWIDTH(16), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .i_data(e2_i_data), .i_data_valid(e2_i_data_valid), .i_data_stop(e2_i_data_stop),
    .o_data(e2_o_data), .o_data_valid(e2_o_data_valid), .o_data_stop(e2_o_data_stop),
    .o_count(e2_o_count), .o_proto_err(e2_o_proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // occupancy/valid/stop/data of the DEPTH=4 instance in one call
  task automatic chk4(input string tag, input int cnt, input logic vld,
                      input logic stp, input logic [15:0] dat);
    chk({tag, ".count"}, 32'(o_count), 32'(cnt));
    chk({tag, ".valid"}, 32'(o_data_valid), 32'(vld));
    chk({tag, ".stop"},  32'(i_data_stop), 32'(stp));
    if (vld) chk({tag, ".data"}, 32'(o_data), 32'(dat));
  endtask

  initial begin
    // reset state
    #1 reset = 1'b1;
    #1;
    chk4("rst", 0, 1'b0, 1'b0, 16'h0);
    chk("rst.data", 32'(o_data), 32'h0);
    chk("rst.err", 32'(o_proto_err), 32'h0);
    #1 reset = 1'b0;

    // single token latency: pushed at edge N, visible in cycle N+1, popped at N+1
    i_data = 16'h1234; i_data_valid = 1'b1; o_data_stop = 1'b0;
    step();
    chk4("lat.n1", 1, 1'b1, 1'b0, 16'h1234);
    i_data_valid = 1'b0;
    step();
    chk4("lat.n2", 0, 1'b0, 1'b0, 16'h0);

    // async reset mid-stream with 3 tokens held
    o_data_stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = 16'h0050 + 16'(i); i_data_valid = 1'b1;
      step();
    end
    i_data_valid = 1'b0;
    chk4("mid.pre", 3, 1'b1, 1'b0, 16'h0050);
    #2 reset = 1'b1;
    #1;
    chk4("mid.rst", 0, 1'b0, 1'b0, 16'h0);
    #1 reset = 1'b0;
    o_data_stop = 1'b0;
    step();
    chk4("mid.lost", 0, 1'b0, 1'b0, 16'h0);

    // fill to full under downstream stop, then hold a 5th token
    o_data_stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = 16'h00A0 + 16'(i); i_data_valid = 1'b1;
      step();
      chk4($sformatf("fill%0d", i), i + 1, 1'b1, (i == 3), 16'h00A0);
    end
    i_data = 16'h00A4;
    step();
    chk4("hold1", 4, 1'b1, 1'b1, 16'h00A0);
    step();
    chk4("hold2", 4, 1'b1, 1'b1, 16'h00A0);
    o_data_stop = 1'b0;
    step();
    chk4("drain1", 3, 1'b1, 1'b0, 16'h00A1);
    step();                                   // A4 pushed, A1 popped
    chk4("drain2", 3, 1'b1, 1'b0, 16'h00A2);
    i_data_valid = 1'b0;
    step();
    chk4("drain3", 2, 1'b1, 1'b0, 16'h00A3);
    step();
    chk4("drain4", 1, 1'b1, 1'b0, 16'h00A4);
    step();
    chk4("drain5", 0, 1'b0, 1'b0, 16'h0);
    chk("drain.err", 32'(o_proto_err), 32'h0);

    // streaming: one token per cycle, occupancy 1, pointers wrap
    for (int i = 0; i < 20; i++) begin
      i_data = 16'(i); i_data_valid = 1'b1;
      step();
      chk4($sformatf("strm%0d", i), 1, 1'b1, 1'b0, 16'(i));
    end
    i_data_valid = 1'b0;
    step();
    chk4("strm.end", 0, 1'b0, 1'b0, 16'h0);

    // push+pop at count=2
    o_data_stop = 1'b1;
    i_data = 16'h00B0; i_data_valid = 1'b1; step();
    i_data = 16'h00B1; step();
    chk4("pp.c2", 2, 1'b1, 1'b0, 16'h00B0);
    o_data_stop = 1'b0;
    i_data = 16'h00B2; step();
    chk4("pp.a", 2, 1'b1, 1'b0, 16'h00B1);
    i_data = 16'h00B3; step();
    chk4("pp.b", 2, 1'b1, 1'b0, 16'h00B2);
    i_data_valid = 1'b0; step();
    chk4("pp.c", 1, 1'b1, 1'b0, 16'h00B3);
    step();
    chk4("pp.d", 0, 1'b0, 1'b0, 16'h0);

    // push+pop at count=1 on DEPTH=2, then fill it
    e2_o_data_stop = 1'b1;
    e2_i_data = 16'h00C0; e2_i_data_valid = 1'b1; step();
    chk("e2.c1", 32'(e2_o_count), 32'd1);
    e2_o_data_stop = 1'b0;
    e2_i_data = 16'h00C1; step();
    chk("e2.pp1.cnt", 32'(e2_o_count), 32'd1);
    chk("e2.pp1.dat", 32'(e2_o_data), 32'h00C1);
    e2_i_data = 16'h00C2; step();
    chk("e2.pp2.cnt", 32'(e2_o_count), 32'd1);
    chk("e2.pp2.dat", 32'(e2_o_data), 32'h00C2);
    e2_o_data_stop = 1'b1;
    e2_i_data = 16'h00C3; step();
    chk("e2.full.cnt", 32'(e2_o_count), 32'd2);
    chk("e2.full.stop", 32'(e2_i_data_stop), 32'd1);
    chk("e2.full.dat", 32'(e2_o_data), 32'h00C2);
    e2_i_data_valid = 1'b0;
    e2_o_data_stop = 1'b0;

    // protocol: valid dropped while stopped
    o_data_stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = 16'h00E0 + 16'(i); i_data_valid = 1'b1; step();
    end
    i_data = 16'h00E4; step();
    chk("pv.before", 32'(o_proto_err), 32'h0);
    i_data_valid = 1'b0; step();
    chk("pv.drop", 32'(o_proto_err), 32'h1);
    o_data_stop = 1'b0;
    step(); step();
    chk("pv.sticky", 32'(o_proto_err), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("pv.rst", 32'(o_proto_err), 32'h0);
    #1 reset = 1'b0;

    // protocol: data changed while stopped
    o_data_stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = 16'h00F0 + 16'(i); i_data_valid = 1'b1; step();
    end
    i_data = 16'h00F4; step();
    chk("pd.before", 32'(o_proto_err), 32'h0);
    i_data = 16'h00F5; step();
    chk("pd.change", 32'(o_proto_err), 32'h1);
    chk4("pd.fifo", 4, 1'b1, 1'b1, 16'h00F0);
    i_data_valid = 1'b0; o_data_stop = 1'b0;
    step();
    chk("pd.sticky", 32'(o_proto_err), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
